// File: rtl/bch_syndrome_pkg.sv
// Shared definitions for the BCH syndrome block: FSM encodings, default
// primitive polynomials for GF(2^3)..GF(2^8), and the GF squaring helper.
package bch_syndrome_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } bch_state_e;

  function automatic logic [8:0] bch_default_poly(input int m);
    case (m)
      3:       return 9'b000001011;
      4:       return 9'b000010011;
      5:       return 9'b000100101;
      6:       return 9'b001000011;
      7:       return 9'b010001001;
      8:       return 9'b100011101;
      default: return 9'b000010011;
    endcase
  endfunction

  // Squaring in GF(2^m) spreads bits to even positions, then reduces mod poly.
  function automatic logic [7:0] gf_sqr(input logic [7:0] a, input int m,
                                        input logic [8:0] poly);
    logic [15:0] p;
    p = '0;
    for (int i = 0; i < 8; i++) p[2*i] = a[i];
    for (int i = 15; i >= 1; i--) begin
      if (i >= m && p[i]) p = p ^ (16'(poly) << (i - m));
    end
    return p[7:0];
  endfunction

endpackage

// File: rtl/bch_syndrome_gf_mulc.sv
// bch_gf_mulc: combinational multiply by the constant alpha^pK in GF(2^pM).
module bch_gf_mulc
  import bch_syndrome_pkg::*;
#(
  parameter int           pM    = 4,
  parameter logic [pM:0]  pPoly = 5'b10011,
  parameter int           pK    = 1
) (
  input  logic [pM-1:0] x,
  output logic [pM-1:0] y
);

  localparam int K = pK % ((1 << pM) - 1);

  // K successive multiply-by-alpha steps; K is a constant so this folds to XORs.
  always_comb begin
    y = x;
    for (int i = 0; i < K; i++) begin
      y = {y[pM-2:0], 1'b0} ^ (y[pM-1] ? pPoly[pM-1:0] : '0);
    end
  end

endmodule

// File: rtl/bch_syndrome.sv
// Bit-serial BCH syndrome calculator (Horner accumulation, MSB-first input).
// Define BCH_SYN_EVEN_EN to also output even syndromes S2k = Sk^2.
//
// state   | meaning
// --------+-----------------------------------------------
// ST_IDLE | waiting for a valid sof bit
// ST_RUN  | accumulating bits 2..pN of the current codeword
module bch_syndrome
  import bch_syndrome_pkg::*;
#(
  parameter int           pM    = 4,
  parameter int           pT    = 2,
  parameter int           pN    = 15,
  parameter logic [pM:0]  pPoly = 5'b10011
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_valid,
  input  logic                  i_sof,
  input  logic                  i_d,
  output logic                  o_busy,
  output logic                  o_valid,
`ifdef BCH_SYN_EVEN_EN
  output logic [2*pT*pM-1:0]    o_syn,
`else
  output logic [pT*pM-1:0]      o_syn,
`endif
  output logic                  o_nz,
  output logic                  o_abort
);

`ifdef BCH_SYN_EVEN_EN
  localparam int NSYN = 2 * pT;
`else
  localparam int NSYN = pT;
`endif
  localparam int CW = (pN > 2) ? $clog2(pN) : 1;

  bch_state_e          state, state_nxt;
  logic [CW-1:0]       cnt_left;
  logic [pM-1:0]       acc      [pT];
  logic [pM-1:0]       acc_mul  [pT];
  logic [pM-1:0]       acc_step [pT];
  logic [pM-1:0]       acc_load;
  logic [pM-1:0]       syn_all  [NSYN];
  logic [NSYN*pM-1:0]  syn_flat;
  logic                do_load, do_step, do_last;

  assign acc_load = {{(pM-1){1'b0}}, i_d};

  for (genvar g = 0; g < pT; g++) begin : g_acc
    bch_gf_mulc #(.pM(pM), .pPoly(pPoly), .pK(2*g + 1)) u_mulc (
      .x (acc[g]),
      .y (acc_mul[g])
    );
    assign acc_step[g] = acc_mul[g] ^ acc_load;
  end

  // Results are formed from the post-update accumulators so they register
  // on the same edge that accepts the last bit.
  always_comb begin
    for (int i = 0; i < NSYN; i++) syn_all[i] = '0;
`ifdef BCH_SYN_EVEN_EN
    for (int i = 0; i < NSYN; i++) begin
      if (i % 2 == 0) syn_all[i] = acc_step[i/2];
      else            syn_all[i] = pM'(gf_sqr(8'(syn_all[(i+1)/2 - 1]), pM, 9'(pPoly)));
    end
`else
    for (int i = 0; i < NSYN; i++) syn_all[i] = acc_step[i];
`endif
    syn_flat = '0;
    for (int i = 0; i < NSYN; i++) syn_flat[i*pM +: pM] = syn_all[i];
  end

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (do_load) state_nxt = ST_RUN;
      ST_RUN:  if (do_last) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // A sof landing in the o_valid cycle starts the next frame immediately.
  always_comb begin
    do_load = i_valid & i_sof;
    do_step = i_valid & ~i_sof & (state == ST_RUN);
    do_last = do_step & (cnt_left == CW'(1));
    o_busy  = (state == ST_RUN) | (o_valid & do_load);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_left <= '0;
      for (int i = 0; i < pT; i++) acc[i] <= '0;
      o_valid  <= 1'b0;
      o_abort  <= 1'b0;
      o_syn    <= '0;
      o_nz     <= 1'b0;
    end else begin
      o_valid <= 1'b0;
      o_abort <= 1'b0;
      if (do_load) begin
        for (int i = 0; i < pT; i++) acc[i] <= acc_load;
        cnt_left <= CW'(pN - 1);
        if (state == ST_RUN) o_abort <= 1'b1;
      end else if (do_step) begin
        for (int i = 0; i < pT; i++) acc[i] <= acc_step[i];
        cnt_left <= cnt_left - CW'(1);
        if (do_last) begin
          o_syn   <= syn_flat;
          o_nz    <= |syn_flat;
          o_valid <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_bch_syndrome.sv
// Self-checking bench for bch_syndrome (GF(16), n=15, t=2); honours BCH_SYN_EVEN_EN.
module tb_bch_syndrome;

`ifdef BCH_SYN_EVEN_EN
  localparam int NSYN = 4;
`else
  localparam int NSYN = 2;
`endif
  localparam int W = NSYN * 4;

  logic         clk = 1'b0;
  logic         rst, i_valid, i_sof, i_d;
  logic         o_busy, o_valid, o_nz, o_abort;
  logic [W-1:0] o_syn;

  bch_syndrome #(.pM(4), .pT(2), .pN(15), .pPoly(5'b10011)) dut (
    .clk     (clk),
    .rst     (rst),
    .i_valid (i_valid),
    .i_sof   (i_sof),
    .i_d     (i_d),
    .o_busy  (o_busy),
    .o_valid (o_valid),
    .o_syn   (o_syn),
    .o_nz    (o_nz),
    .o_abort (o_abort)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  int vcount = 0;
  int acount = 0;
  int n_chk = 0;
  int n_fail = 0;
  int sof_cyc = 0;
  logic [W-1:0] prev_exp = '0;

  always @(posedge clk) cyc++;
  always @(posedge clk) begin
    #2;
    if (o_valid === 1'b1) vcount++;
    if (o_abort === 1'b1) acount++;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: time limit reached, n_chk=%0d", n_chk);
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Reference model: r(x) evaluated at alpha^j using field multiplication.
  function automatic logic [3:0] gf_mul(input logic [3:0] a, input logic [3:0] b);
    logic [7:0] p;
    p = '0;
    for (int i = 0; i < 4; i++) if (b[i]) p = p ^ (8'(a) << i);
    for (int i = 7; i >= 4; i--) if (p[i]) p = p ^ (8'b00010011 << (i - 4));
    return p[3:0];
  endfunction

  function automatic logic [3:0] alpha_pow(input int e);
    logic [3:0] r;
    r = 4'b0001;
    for (int k = 0; k < e % 15; k++) r = gf_mul(r, 4'b0010);
    return r;
  endfunction

  function automatic logic [3:0] syn_j(input logic [14:0] r, input int j);
    logic [3:0] s;
    s = '0;
    for (int i = 0; i < 15; i++) if (r[i]) s = s ^ alpha_pow(i * j);
    return s;
  endfunction

  function automatic logic [W-1:0] exp_pack(input logic [14:0] r);
    logic [W-1:0] v;
    v = '0;
    for (int k = 0; k < NSYN; k++) begin
`ifdef BCH_SYN_EVEN_EN
      v[4*k +: 4] = syn_j(r, k + 1);
`else
      v[4*k +: 4] = syn_j(r, 2*k + 1);
`endif
    end
    return v;
  endfunction

  function automatic logic [3:0] field(input logic [W-1:0] v, input int j);
`ifdef BCH_SYN_EVEN_EN
    return v[4*(j-1) +: 4];
`else
    return v[4*((j-1)/2) +: 4];
`endif
  endfunction

  task automatic drive(input logic v, input logic s, input logic d);
    @(negedge clk);
    i_valid = v;
    i_sof   = s;
    i_d     = d;
    #1;
  endtask

  task automatic send_bits(input logic [14:0] r, input int hi, input int lo,
                           input bit sof_first, input int gap_max);
    for (int i = hi; i >= lo; i--) begin
      if (gap_max > 0)
        repeat ($urandom_range(0, gap_max))
          drive(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      if (sof_first && i == hi) begin
        drive(1'b1, 1'b1, r[i]);
        sof_cyc = cyc + 1;
      end else begin
        drive(1'b1, 1'b0, r[i]);
      end
    end
  endtask

  task automatic finish_frame(input string tag, input logic [14:0] r);
    logic [W-1:0] e;
    e = exp_pack(r);
    drive(1'b0, 1'b0, 1'b0);
    check_eq({tag, "_valid"}, 64'(o_valid), 64'(1'b1));
    check_eq({tag, "_syn"},   64'(o_syn),   64'(e));
    check_eq({tag, "_nz"},    64'(o_nz),    64'(e != '0));
    check_eq({tag, "_busy"},  64'(o_busy),  64'(1'b0));
    drive(1'b0, 1'b0, 1'b0);
    check_eq({tag, "_pulse"}, 64'(o_valid), 64'(1'b0));
    prev_exp = e;
  endtask

  initial begin
    logic [14:0] r, b;
    int vbefore, abefore;
    rst = 1'b1; i_valid = 1'b0; i_sof = 1'b0; i_d = 1'b0;
    repeat (3) drive(1'b0, 1'b0, 1'b0);
    @(negedge clk); rst = 1'b0; #1;
    check_eq("rst_valid", 64'(o_valid), 64'(1'b0));
    check_eq("rst_busy",  64'(o_busy),  64'(1'b0));
    check_eq("rst_syn",   64'(o_syn),   64'(0));
    check_eq("rst_nz",    64'(o_nz),    64'(1'b0));
    check_eq("rst_abort", 64'(o_abort), 64'(1'b0));

    // all-zero codeword and o_valid latency
    send_bits(15'd0, 14, 0, 1'b1, 0);
    check_eq("zero_busy", 64'(o_busy), 64'(1'b1));
    drive(1'b0, 1'b0, 1'b0);
    check_eq("zero_latency", 64'(cyc - sof_cyc), 64'(14));
    check_eq("zero_valid", 64'(o_valid), 64'(1'b1));
    check_eq("zero_syn", 64'(o_syn), 64'(0));
    check_eq("zero_nz", 64'(o_nz), 64'(1'b0));

    // generator polynomial is a codeword, with and without gaps
    r = 15'b000000111010001;
    send_bits(r, 14, 0, 1'b1, 0);
    finish_frame("gx", r);
    check_eq("gx_s1", 64'(field(o_syn, 1)), 64'(0));
    check_eq("gx_s3", 64'(field(o_syn, 3)), 64'(0));
    send_bits(r, 14, 0, 1'b1, 3);
    finish_frame("gx_gap", r);
    check_eq("gx_gap_nz", 64'(o_nz), 64'(1'b0));

    r = 15'b000000000000001;
    send_bits(r, 14, 0, 1'b1, 0);
    finish_frame("r0", r);
    check_eq("r0_s1", 64'(field(o_syn, 1)), 64'(4'b0001));
    check_eq("r0_s3", 64'(field(o_syn, 3)), 64'(4'b0001));

    r = 15'b000000000000010;
    send_bits(r, 14, 0, 1'b1, 0);
    finish_frame("r1", r);
    check_eq("r1_s1", 64'(field(o_syn, 1)), 64'(4'b0010));
    check_eq("r1_s3", 64'(field(o_syn, 3)), 64'(4'b1000));

    // r14 error then a back-to-back frame
    r = 15'b100000000000000;
    b = 15'($urandom);
    send_bits(r, 14, 0, 1'b1, 0);
    drive(1'b1, 1'b1, b[14]);
    check_eq("b2b_valid", 64'(o_valid), 64'(1'b1));
    check_eq("b2b_busy",  64'(o_busy),  64'(1'b1));
    check_eq("r14_s1", 64'(field(o_syn, 1)), 64'(4'b1001));
    check_eq("r14_s3", 64'(field(o_syn, 3)), 64'(4'b1111));
    check_eq("r14_nz", 64'(o_nz), 64'(1'b1));
`ifdef BCH_SYN_EVEN_EN
    check_eq("r14_s2", 64'(field(o_syn, 2)), 64'(4'b1101));
    check_eq("r14_s4", 64'(field(o_syn, 4)), 64'(4'b1110));
`endif
    send_bits(b, 13, 0, 1'b0, 0);
    finish_frame("b2b", b);

    // sof reasserted at bit 7 aborts the frame in progress
    r = 15'($urandom);
    b = 15'($urandom) | 15'h0100;
    abefore = acount;
    send_bits(r, 14, 9, 1'b1, 0);
    send_bits(b, 14, 14, 1'b1, 0);
    drive(1'b1, 1'b0, b[13]);
    check_eq("abort_pulse", 64'(o_abort), 64'(1'b1));
    check_eq("abort_syn_hold", 64'(o_syn), 64'(prev_exp));
    check_eq("abort_busy", 64'(o_busy), 64'(1'b1));
    send_bits(b, 12, 0, 1'b0, 0);
    finish_frame("abort_new", b);
    check_eq("abort_count", 64'(acount - abefore), 64'(1));

    // reset mid-frame, then non-sof bits in IDLE are ignored
    r = 15'($urandom);
    vbefore = vcount;
    abefore = acount;
    send_bits(r, 14, 10, 1'b1, 0);
    @(negedge clk); rst = 1'b1; i_valid = 1'b0; i_sof = 1'b0;
    @(negedge clk); rst = 1'b0; #1;
    check_eq("midrst_syn",  64'(o_syn),  64'(0));
    check_eq("midrst_nz",   64'(o_nz),   64'(1'b0));
    check_eq("midrst_busy", 64'(o_busy), 64'(1'b0));
    send_bits(r, 9, 0, 1'b0, 0);
    repeat (3) drive(1'b0, 1'b0, 1'b0);
    check_eq("idle_ignore_valid", 64'(vcount - vbefore), 64'(0));
    check_eq("idle_ignore_abort", 64'(acount - abefore), 64'(0));
    check_eq("idle_ignore_busy",  64'(o_busy), 64'(1'b0));
    check_eq("idle_ignore_syn",   64'(o_syn), 64'(0));

    // randomized frames with random gaps
    for (int f = 0; f < 20; f++) begin
      r = 15'($urandom);
      if (f % 4 == 0) r = r & 15'h0003;
      send_bits(r, 14, 0, 1'b1, 3);
      finish_frame("rand", r);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
